// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor (diff = a - b), LSB first, one bit per clock, start/busy/done handshake.
// Optional build macro SUB_SATURATE_EN: an underflowing result (borrow=1) loads diff as zero.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic             br;
    logic             br_next;
    logic             d;
    logic             accept;
    logic             step;
    logic             finish;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == LAST) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // One full-subtractor bit; the new result bit enters at the MSB so that
    // after WIDTH steps the LSB-first stream sits in natural bit order.
    always_comb begin
        d        = a_sr[0] ^ b_sr[0] ^ br;
        br_next  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
        res_next = res_sr >> 1;
        res_next[WIDTH-1] = d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            borrow <= 1'b0;
        end else if (accept) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            br     <= 1'b0;
            cnt    <= '0;
        end else if (step) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= res_next;
            br     <= br_next;
            cnt    <= cnt + CW'(1);
            if (finish) begin
`ifdef SUB_SATURATE_EN
                diff <= br_next ? '0 : res_next;
`else
                diff <= res_next;
`endif
                borrow <= br_next;
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    a_busy_done_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(busy && done));

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed operands with hand-computed results;
// a negedge monitor pops expected {borrow, diff} whenever done is seen.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W:0]   exp_q[$];
    logic [W-1:0] hold_diff;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [W-1:0] exp_diff(input logic [W-1:0] wrap, input logic brw);
`ifdef SUB_SATURATE_EN
        return brw ? '0 : wrap;
`else
        return wrap;
`endif
    endfunction

    // Monitor: every done cycle must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                check("result_diff",   {24'd0, diff}, {24'd0, e[W-1:0]});
                check("result_borrow", {31'd0, borrow}, {31'd0, e[W]});
            end
        end
    end

    // Called at a negedge; returns at the negedge of the DONE cycle with start low.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] wrap, input logic brw);
        start = 1'b1;
        a     = av;
        b     = bv;
        exp_q.push_back({brw, exp_diff(wrap, brw)});
        for (int k = 1; k <= W; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                a     = 8'hA5;
                b     = 8'h3C;
            end
            if (k == 4) start = 1'b1;
            if (k == 5) start = 1'b0;
            check("run_busy", {31'd0, busy}, 32'd1);
            check("run_no_done", {31'd0, done}, 32'd0);
            check("run_diff_hold", {24'd0, diff}, {24'd0, hold_diff});
        end
        @(negedge clk);
        check("done_pulse", {31'd0, done}, 32'd1);
        check("done_not_busy", {31'd0, busy}, 32'd0);
        hold_diff = exp_diff(wrap, brw);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        a         = '0;
        b         = '0;
        hold_diff = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy",   {31'd0, busy},   32'd0);
        check("rst_done",   {31'd0, done},   32'd0);
        check("rst_diff",   {24'd0, diff},   32'd0);
        check("rst_borrow", {31'd0, borrow}, 32'd0);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_busy", {31'd0, busy}, 32'd0);
            check("idle_done", {31'd0, done}, 32'd0);
        end

        // Single operations with idle gaps
        run_op(8'd100, 8'd58, 8'd42,  1'b0);
        @(negedge clk);
        check("idle_after_done", {30'd0, busy, done}, 32'd0);
        run_op(8'd5,   8'd7,  8'hFE,  1'b1);
        @(negedge clk);
        run_op(8'hFF,  8'hFF, 8'h00,  1'b0);
        @(negedge clk);
        run_op(8'h00,  8'h01, 8'hFF,  1'b1);
        @(negedge clk);
        run_op(8'h80,  8'h7F, 8'h01,  1'b0);
        @(negedge clk);
        check("hold_after_op", {24'd0, diff}, {24'd0, hold_diff});

        // Back-to-back: start held high, operands changed mid-RUN, next op loaded in DONE
        start = 1'b1;
        a = 8'd200; b = 8'd55;
        exp_q.push_back({1'b0, exp_diff(8'd145, 1'b0)});
        for (int op = 0; op < 3; op++) begin
            for (int k = 1; k <= W; k++) begin
                @(negedge clk);
                a = 8'hAA ^ 8'(k);
                b = 8'h55;
                check("b2b_busy", {31'd0, busy}, 32'd1);
            end
            @(negedge clk);
            check("b2b_done_spacing", {31'd0, done}, 32'd1);
            if (op == 0) begin
                a = 8'd17; b = 8'd34;
                exp_q.push_back({1'b1, exp_diff(8'd239, 1'b1)});
            end else if (op == 1) begin
                a = 8'd128; b = 8'd1;
                exp_q.push_back({1'b0, exp_diff(8'd127, 1'b0)});
            end else begin
                start = 1'b0;
            end
        end
        hold_diff = 8'd127;
        @(negedge clk);
        check("b2b_back_idle", {30'd0, busy, done}, 32'd0);

        // Reset mid-operation: after four bits processed; no done for this op
        start = 1'b1;
        a = 8'd9; b = 8'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy",   {31'd0, busy},   32'd0);
        check("midrst_done",   {31'd0, done},   32'd0);
        check("midrst_diff",   {24'd0, diff},   32'd0);
        check("midrst_borrow", {31'd0, borrow}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        hold_diff = '0;
        repeat (12) begin
            @(negedge clk);
            check("midrst_no_done", {31'd0, done}, 32'd0);
        end
        run_op(8'd60, 8'd61, 8'hFF, 1'b1);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
